// File: rtl/timer_psc_tick_gen.sv
//------------------------------------------------------------------------------
// timer_psc_tick_gen
//
// Prescaler tick generator for the APB4 timer counter. It divides clk_i by a
// programmable integer divisor and emits a one-cycle tick_o enable pulse once
// per divisor period. New divisors arrive over a valid/ready handshake. The
// counter restarts from 0 on every accepted update.
//
// Parameters:
//   CNT_WIDTH  width of the divisor and the prescaler counter
//   DIV_RST    divisor used after reset (must be >= 2)
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   en_i         count enable
//   div_i        requested divisor (values below 2 are clamped to 2)
//   div_valid_i  divisor update request
//   div_ready_o  update can be accepted (low only in LOAD)
//   div_done_o   active divisor loaded and counting (high only in RUN)
//   tick_o       one-cycle pulse per divisor period
//   cnt_o        current prescaler count
//   clk_o        divided clock output
//
// Build option:
//   TIMER_PSC_CLK_OUT_EN  when defined, clk_o is a registered divided clock.
//                         It is high for div - (div >> 1) cycles per period.
//                         When undefined, clk_o is tied to 0.
//------------------------------------------------------------------------------
module timer_psc_tick_gen #(
    parameter int unsigned CNT_WIDTH = 20,
    parameter int unsigned DIV_RST   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_done_o,
    output logic                 tick_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 clk_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] div_q;
    logic [CNT_WIDTH-1:0] pend_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 tick_q;
    logic                 ready_q;
    logic                 done_q;

    logic                 accept;
    logic [CNT_WIDTH-1:0] div_clamped;
    logic                 wrap;

    assign accept      = div_valid_i & ready_q;
    assign div_clamped = (div_i < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : div_i;
    assign wrap        = (cnt_q == div_q - CNT_WIDTH'(1));

    // An accept always wins over a wrap in the same cycle: the counter and
    // the tick are cleared right away so LOAD shows a clean zero state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= CNT_WIDTH'(DIV_RST);
            pend_q  <= CNT_WIDTH'(DIV_RST);
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pend_q  <= div_clamped;
                        state_q <= LOAD;
                        ready_q <= 1'b0;
                    end else begin
                        div_q   <= CNT_WIDTH'(DIV_RST);
                        cnt_q   <= '0;
                        state_q <= RUN;
                        done_q  <= 1'b1;
                    end
                    tick_q <= 1'b0;
                end
                LOAD: begin
                    div_q   <= pend_q;
                    cnt_q   <= '0;
                    tick_q  <= 1'b0;
                    state_q <= RUN;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                RUN: begin
                    if (accept) begin
                        pend_q  <= div_clamped;
                        cnt_q   <= '0;
                        tick_q  <= 1'b0;
                        state_q <= LOAD;
                        ready_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (en_i) begin
                        if (wrap) begin
                            cnt_q  <= '0;
                            tick_q <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + CNT_WIDTH'(1);
                            tick_q <= 1'b0;
                        end
                    end else begin
                        tick_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= 1'b0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_ready_o = ready_q;
    assign div_done_o  = done_q;
    assign tick_o      = tick_q;
    assign cnt_o       = cnt_q;

`ifdef TIMER_PSC_CLK_OUT_EN
    logic                 clk_q;
    logic [CNT_WIDTH-1:0] half_m1;

    assign half_m1 = (div_q >> 1) - CNT_WIDTH'(1);

    // Toggling at the half point and at the wrap point gives a level that
    // is high for div - (div >> 1) cycles, so odd divisors lean high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_q <= 1'b0;
        end else if (state_q != RUN || accept) begin
            clk_q <= 1'b0;
        end else if (en_i && (cnt_q == half_m1 || wrap)) begin
            clk_q <= ~clk_q;
        end
    end

    assign clk_o = clk_q;
`else
    assign clk_o = 1'b0;
`endif

endmodule
